spi_accel_slave: RTL and testbench

SPI responder that models the accelerometer end of the sensor link: a 64 x 8 register file with read/write access over 4-wire SPI mode 3 and a local port that loads new X/Y/Z samples. It sits opposite the design's SPI master, either as the in-FPGA sensor model for simulation and loopback, or as the slave side of a board-to-board link. All SPI inputs are oversampled in the system clock domain. No SCLK-domain logic is used.

---
 rtl/spi_accel_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_accel_slave.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_slave.sv
// SPI mode-3 responder modelling a 64x8 accelerometer register file.
// Define SPI_SLAVE_SNAPSHOT_EN to freeze sample registers for each frame.
module spi_accel_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        sample_valid,
    input  logic [47:0] sample_data,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE
    } state_t;

    localparam logic [5:0] SAMPLE_LO = 6'h32;
    localparam logic [5:0] SAMPLE_HI = 6'h37;
    localparam logic [7:0] ID_VAL    = 8'hE5;

    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q, cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [5:0] addr_q, addr_d;
    logic       mb_q, mb_d;
    logic [7:0] miso_sr_q, miso_sr_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [5:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q, busy_d;
    logic [7:0] regs_q [64];
    logic [7:0] regs_d [64];

    logic        sclk_rise, cs_fall, cs_rise, byte_done;
    logic        wr_en, sample_load;
    logic [7:0]  shift_in, rd_data;
    logic [5:0]  addr_next, rd_addr;
    logic [47:0] sample_word;

    function automatic logic is_sample(input logic [5:0] a);
        return (a >= SAMPLE_LO) && (a <= SAMPLE_HI);
    endfunction

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        cs_sync_d   = {cs_sync_q[1:0], CS};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
    end

    // Synchronizers follow the pins through reset, so a CS already low
    // at reset release is not mistaken for a fresh fall.
    always_ff @(posedge clk) begin
        sclk_sync_q <= sclk_sync_d;
        cs_sync_q   <= cs_sync_d;
        mosi_sync_q <= mosi_sync_d;
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign shift_in  = {shift_q[6:0], mosi_sync_q[1]};
    assign byte_done = sclk_rise & (bit_cnt_q == 3'd7) & ~cs_rise;
    assign addr_next = mb_q ? addr_q + 6'd1 : addr_q;
    assign rd_addr   = (state_q == S_CMD) ? shift_in[5:0] : addr_next;

`ifdef SPI_SLAVE_SNAPSHOT_EN
    logic [7:0]  shadow_q [8];
    logic [7:0]  shadow_d [8];
    logic        pend_q, pend_d;
    logic [47:0] pend_data_q, pend_data_d;

    always_comb begin
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        sample_load = 1'b0;
        sample_word = sample_data;
        if (cs_fall) begin
            for (int i = 0; i < 6; i++)
                shadow_d[i] = regs_q[SAMPLE_LO + 6'(i)];
        end
        // Samples arriving mid-frame wait until CS is back high.
        if (cs_sync_q[1]) begin
            sample_load = sample_valid | pend_q;
            sample_word = sample_valid ? sample_data : pend_data_q;
            pend_d      = 1'b0;
        end else if (sample_valid) begin
            pend_d      = 1'b1;
            pend_data_d = sample_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '{default: '0};
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign rd_data = (rd_addr == 6'h00) ? ID_VAL :
                     is_sample(rd_addr) ? shadow_q[3'(rd_addr - SAMPLE_LO)] :
                     regs_q[rd_addr];
`else
    assign sample_load = sample_valid;
    assign sample_word = sample_data;
    assign rd_data     = (rd_addr == 6'h00) ? ID_VAL : regs_q[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (cs_fall) state_d = S_CMD;
                S_CMD:   if (byte_done)
                             state_d = shift_in[7] ? S_RDATA : S_WDATA;
                S_WDATA: if (byte_done && !mb_q) state_d = S_DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        MISO = 1'b0;
        if (state_q == S_RDATA) MISO = miso_sr_q[7];
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        mb_d        = mb_q;
        miso_sr_d   = miso_sr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en       = 1'b0;
        busy_d      = ~cs_sync_q[0];
        if (state_q == S_IDLE) begin
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_in;
        end
        unique case (state_q)
            S_CMD: if (byte_done) begin
                addr_d    = shift_in[5:0];
                mb_d      = shift_in[6];
                miso_sr_d = rd_data;
            end
            S_WDATA: if (byte_done) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = shift_in;
                wr_en       = (addr_q != 6'h00) && !is_sample(addr_q);
                addr_d      = addr_next;
            end
            S_RDATA: if (sclk_rise && !cs_rise) begin
                miso_sr_d = byte_done ? rd_data : {miso_sr_q[6:0], 1'b0};
                if (byte_done) addr_d = addr_next;
            end
            default: ;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (sample_load) begin
            for (int i = 0; i < 6; i++)
                regs_d[SAMPLE_LO + 6'(i)] = sample_word[8*i +: 8];
        end
        if (wr_en) regs_d[addr_q] = shift_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            mb_q        <= 1'b0;
            miso_sr_q   <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            mb_q        <= mb_d;
            miso_sr_q   <= miso_sr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            regs_q      <= regs_d;
        end
    end

    assign reg_wr_strobe = wr_strobe_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_spi_accel_slave.sv
// Bench for spi_accel_slave: directed scenarios plus random frames
// checked against a register-map reference model.
module tb_spi_accel_slave;
    logic        clk = 1'b0;
    logic        reset, SCLK, CS, MOSI, sample_valid;
    logic [47:0] sample_data;
    logic        MISO, reg_wr_strobe, busy;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;

    always #5 clk = ~clk;

    spi_accel_slave dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .sample_valid(sample_valid), .sample_data(sample_data),
        .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .busy(busy)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  mregs [64];
    logic [7:0]  tx_buf [16];
    logic [7:0]  rx_buf [16];
    int          inject_bit = -1;
    logic [47:0] inject_val = '0;
    logic [13:0] strobes [$];

    always @(negedge clk)
        if (reg_wr_strobe) strobes.push_back({reg_wr_addr, reg_wr_data});

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m_rd(input logic [5:0] a);
        return (a == 6'h00) ? 8'hE5 : mregs[a];
    endfunction

    function automatic void m_wr(input logic [5:0] a, input logic [7:0] d);
        if (a != 6'h00 && !(a >= 6'h32 && a <= 6'h37)) mregs[a] = d;
    endfunction

    function automatic void m_sample(input logic [47:0] v);
        for (int i = 0; i < 6; i++) mregs[6'h32 + i] = v[8*i +: 8];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
    endfunction

    task automatic frame(input int nbits, input bit drive_cs);
        @(negedge clk);
        if (drive_cs) CS = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = tx_buf[i/8][7 - (i%8)];
            if (i == inject_bit) begin
                sample_data  = inject_val;
                sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            rx_buf[i/8][7 - (i%8)] = MISO;
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        if (drive_cs) CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_write(input logic [5:0] a, input bit mb, input int n);
        int nexp;
        logic [5:0] ea;
        tx_buf[0] = {1'b0, mb, a};
        strobes.delete();
        frame(8*(n+1), 1'b1);
        nexp = mb ? n : 1;
        check("wr_count", strobes.size(), nexp);
        for (int k = 0; k < nexp; k++) begin
            ea = a + 6'(k);
            check("wr_strobe", (k < strobes.size()) ? strobes[k] : 14'h0,
                  {ea, tx_buf[k+1]});
            m_wr(ea, tx_buf[k+1]);
        end
    endtask

    task automatic spi_read(input logic [5:0] a, input bit mb, input int n);
        logic [7:0] exp [16];
        for (int k = 0; k < n; k++) begin
            exp[k] = m_rd(mb ? a + 6'(k) : a);
            tx_buf[k+1] = 8'($urandom);
        end
        tx_buf[0] = {1'b1, mb, a};
        strobes.delete();
        frame(8*(n+1), 1'b1);
        for (int k = 0; k < n; k++) check("rd_byte", rx_buf[k+1], exp[k]);
        check("rd_nostrobe", strobes.size(), 0);
    endtask

    task automatic pulse_sample(input logic [47:0] v);
        @(negedge clk);
        sample_data  = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_sample(v);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [47:0] va, vb;
        int op;
        reset = 1'b1; CS = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        sample_valid = 1'b0; sample_data = '0;
        m_reset();
        repeat (6) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", reg_wr_strobe, 0);
        check("rst_addr", reg_wr_addr, 0);
        check("rst_data", reg_wr_data, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        tx_buf[1] = 8'h08;
        spi_write(6'h2D, 1'b0, 1);
        spi_read(6'h2D, 1'b0, 1);

        spi_read(6'h00, 1'b0, 1);
        tx_buf[1] = 8'h55;
        spi_write(6'h00, 1'b0, 1);
        spi_read(6'h00, 1'b0, 1);

        pulse_sample(48'h0605_0403_0201);
        spi_read(6'h32, 1'b1, 6);

        tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
        spi_write(6'h3F, 1'b1, 2);
        spi_read(6'h3F, 1'b1, 2);
        spi_read(6'h3F, 1'b0, 2);

        tx_buf[1] = 8'h3C;
        spi_write(6'h10, 1'b0, 1);
        tx_buf[0] = 8'h10; tx_buf[1] = 8'hFF;
        strobes.delete();
        frame(12, 1'b1);
        check("abort_nostrobe", strobes.size(), 0);
        check("abort_idle", busy, 0);
        spi_read(6'h10, 1'b0, 1);
        tx_buf[1] = 8'h77;
        spi_write(6'h11, 1'b0, 1);
        spi_read(6'h11, 1'b0, 1);

        va = 48'h6655_4433_2211;
        vb = 48'hCCBB_AA99_8877;
        pulse_sample(va);
        tx_buf[0] = 8'hF2;
        for (int k = 1; k < 7; k++) tx_buf[k] = 8'h00;
        inject_bit = 23;
        inject_val = vb;
        frame(56, 1'b1);
        inject_bit = -1;
        for (int k = 0; k < 6; k++) begin
`ifdef SPI_SLAVE_SNAPSHOT_EN
            check("snap_byte", rx_buf[k+1], va[8*k +: 8]);
`else
            check("snap_byte", rx_buf[k+1], (k < 2) ? va[8*k +: 8] : vb[8*k +: 8]);
`endif
        end
        m_sample(vb);
        spi_read(6'h32, 1'b1, 6);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                int n = $urandom_range(1, 3);
                for (int k = 1; k <= n; k++) tx_buf[k] = 8'($urandom);
                spi_write(6'($urandom), 1'($urandom), n);
            end else if (op == 1) begin
                spi_read(6'($urandom), 1'($urandom), $urandom_range(1, 3));
            end else begin
                pulse_sample({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
            end
        end

        @(negedge clk);
        CS = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
        check("rst_cs_low_busy", busy, 1);
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h00;
        frame(16, 1'b0);
        check("rst_cs_low_idle", rx_buf[1], 8'h00);
        CS = 1'b1;
        repeat (8) @(negedge clk);
        spi_read(6'h2D, 1'b0, 1);
        spi_read(6'h3F, 1'b0, 1);
        spi_read(6'h00, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
